// File: rtl/token_fork.sv
// token_fork: fans one result packet out into one or two join tokens over valid/ready
module token_fork #(
  parameter int TAG_W  = 18,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CP,
  input  logic              MR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [TAG_W-1:0]  IN_TAG_A,
  input  logic              IN_LR_A,
  input  logic              IN_DUAL,
  input  logic [TAG_W-1:0]  IN_TAG_B,
  input  logic              IN_LR_B,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [TAG_W:0]    OUT_TOKEN,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CNT_W-1:0]  TOK_CNT,
  output logic              DUP_ERR
);
  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;
  state_t              state_q, state_d;
  logic [TAG_W:0]      a_q, a_d, b_q, b_d, tok_q, tok_d;
  logic [DATA_W-1:0]   data_q, data_d, odata_q, odata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dual_q, dual_d, dup_q, dup_d;
  logic                hs, last, acc, same;
  assign OUT_VALID = state_q != IDLE;
  assign OUT_TOKEN = tok_q;
  assign OUT_DATA  = odata_q;
  assign TOK_CNT   = cnt_q;
  assign DUP_ERR   = dup_q;
  // handshake decode, next state and the values the output registers take next
  always_comb begin
    hs       = OUT_VALID & OUT_READY;
    last     = (state_q == SEND_A & ~dual_q) | state_q == SEND_B;
    IN_READY = MR & (state_q == IDLE | (hs & last));
    acc      = IN_VALID & IN_READY;
    same     = IN_TAG_A == IN_TAG_B & IN_LR_A == IN_LR_B;
    state_d  = acc ? SEND_A
             : (hs & state_q == SEND_A & dual_q) ? SEND_B
             : hs ? IDLE : state_q;
    a_d      = acc ? {IN_TAG_A, IN_LR_A} : a_q;
    b_d      = acc ? {IN_TAG_B, IN_LR_B} : b_q;
    dual_d   = acc ? IN_DUAL & ~same : dual_q;
    data_d   = acc ? IN_DATA : data_q;
    tok_d    = state_d == SEND_A ? a_d : state_d == SEND_B ? b_d : '0;
    odata_d  = state_d == IDLE ? '0 : data_d;
    cnt_d    = (hs & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    dup_d    = acc & IN_DUAL & same;
  end
  // state and output registers; reset discards any packet in flight
  always_ff @(posedge CP) begin
    if (!MR) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dual_q  <= 1'b0;
      data_q  <= '0;
      tok_q   <= '0;
      odata_q <= '0;
      cnt_q   <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dual_q  <= dual_d;
      data_q  <= data_d;
      tok_q   <= tok_d;
      odata_q <= odata_d;
      cnt_q   <= cnt_d;
      dup_q   <= dup_d;
    end
  end
endmodule

// File: tb/tb_token_fork.sv
// tb_token_fork: directed and random stimulus against a token-queue reference model
module tb_token_fork;
  localparam int TAG_W = 18, DATA_W = 16;
  logic              CP = 0, MR = 0, IN_VALID = 0, IN_LR_A = 0, IN_DUAL = 0, IN_LR_B = 0, OUT_READY = 1;
  logic [TAG_W-1:0]  IN_TAG_A = '0, IN_TAG_B = '0;
  logic [DATA_W-1:0] IN_DATA = '0;
  logic              IN_READY, OUT_VALID, DUP_ERR, IN_READY2, OUT_VALID2, DUP_ERR2;
  logic [TAG_W:0]    OUT_TOKEN, OUT_TOKEN2;
  logic [DATA_W-1:0] OUT_DATA, OUT_DATA2;
  logic [15:0]       TOK_CNT;
  logic [1:0]        TOK_CNT2;
  int errs = 0, checks = 0;
  logic [TAG_W:0]    mq[$];
  logic [DATA_W-1:0] m_data = '0;
  int                m_cnt = 0, m_cnt2 = 0;
  logic              m_dup = 0;

  token_fork #(.TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
    .CP(CP), .MR(MR), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_TAG_A(IN_TAG_A),
    .IN_LR_A(IN_LR_A), .IN_DUAL(IN_DUAL), .IN_TAG_B(IN_TAG_B), .IN_LR_B(IN_LR_B),
    .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_TOKEN(OUT_TOKEN),
    .OUT_DATA(OUT_DATA), .TOK_CNT(TOK_CNT), .DUP_ERR(DUP_ERR));
  token_fork #(.TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(2)) sat (
    .CP(CP), .MR(MR), .IN_VALID(IN_VALID), .IN_READY(IN_READY2), .IN_TAG_A(IN_TAG_A),
    .IN_LR_A(IN_LR_A), .IN_DUAL(IN_DUAL), .IN_TAG_B(IN_TAG_B), .IN_LR_B(IN_LR_B),
    .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID2), .OUT_READY(OUT_READY), .OUT_TOKEN(OUT_TOKEN2),
    .OUT_DATA(OUT_DATA2), .TOK_CNT(TOK_CNT2), .DUP_ERR(DUP_ERR2));

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model across the edge.
  task automatic step();
    logic v, hs, rdy, acc, same;
    @(negedge CP);
    v   = mq.size() != 0;
    hs  = v & OUT_READY;
    rdy = MR & (mq.size() == 0 | (hs & mq.size() == 1));
    chk("out_valid", 32'(OUT_VALID), 32'(v));
    chk("in_ready", 32'(IN_READY), 32'(rdy));
    chk("tok_cnt", 32'(TOK_CNT), 32'(m_cnt));
    chk("tok_cnt_sat", 32'(TOK_CNT2), 32'(m_cnt2));
    chk("dup_err", 32'(DUP_ERR), 32'(m_dup));
    if (v) begin
      chk("out_token", 32'(OUT_TOKEN), 32'(mq[0]));
      chk("out_data", 32'(OUT_DATA), 32'(m_data));
    end
    acc  = IN_VALID & rdy;
    same = IN_TAG_A == IN_TAG_B && IN_LR_A == IN_LR_B;
    @(posedge CP);
    if (!MR) begin
      mq.delete();
      m_cnt = 0; m_cnt2 = 0; m_dup = 0;
    end else begin
      if (hs) begin
        void'(mq.pop_front());
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      m_dup = acc & IN_DUAL & same;
      if (acc) begin
        mq.push_back({IN_TAG_A, IN_LR_A});
        if (IN_DUAL && !same) mq.push_back({IN_TAG_B, IN_LR_B});
        m_data = IN_DATA;
      end
    end
    #1;
  endtask

  task automatic pkt(input logic [TAG_W-1:0] ta, input logic la, input logic d,
                     input logic [TAG_W-1:0] tb, input logic lb, input logic [DATA_W-1:0] dat);
    IN_TAG_A = ta; IN_LR_A = la; IN_DUAL = d; IN_TAG_B = tb; IN_LR_B = lb; IN_DATA = dat;
  endtask

  initial begin
    MR = 0;
    repeat (2) step();
    chk("rst_token", 32'(OUT_TOKEN), 0);
    chk("rst_data", 32'(OUT_DATA), 0);
    chk("rst_ready", 32'(IN_READY), 0);
    MR = 1;
    step();
    // single packet
    pkt(18'h12345, 0, 0, 18'h0, 0, 16'h00AA); IN_VALID = 1; OUT_READY = 1;
    step();
    IN_VALID = 0;
    chk("t1_token", 32'(OUT_TOKEN), 32'h2468A);
    chk("t1_data", 32'(OUT_DATA), 32'h00AA);
    step();
    chk("t1_one_cycle", 32'(OUT_VALID), 0);
    chk("t1_cnt", 32'(TOK_CNT), 1);
    // dual packet
    pkt(18'h10, 0, 1, 18'h20, 1, 16'h1234); IN_VALID = 1;
    step();
    IN_VALID = 0;
    chk("t2_tok_a", 32'(OUT_TOKEN), 32'h20);
    chk("t2_ready_a", 32'(IN_READY), 0);
    step();
    chk("t2_tok_b", 32'(OUT_TOKEN), 32'h41);
    step();
    chk("t2_cnt", 32'(TOK_CNT), 3);
    // backpressure
    pkt(18'h2AAAA, 1, 1, 18'h15555, 0, 16'hBEEF); IN_VALID = 1; OUT_READY = 0;
    step();
    IN_VALID = 0;
    for (int i = 0; i < 5; i++) begin
      pkt(18'($urandom), 1'($urandom), 1, 18'($urandom), 0, 16'($urandom)); IN_VALID = 1'($urandom);
      chk("t3_hold", 32'(OUT_TOKEN), 32'h55555);
      step();
    end
    IN_VALID = 0; OUT_READY = 1;
    chk("t3_hold_last", 32'(OUT_TOKEN), 32'h55555);
    step();
    chk("t3_tok_b", 32'(OUT_TOKEN), 32'h2AAAA);
    step();
    // back-to-back singles
    IN_VALID = 1;
    for (int i = 0; i < 4; i++) begin
      pkt(18'(i + 1), 1'(i), 0, 18'h0, 0, 16'(i));
      step();
      chk("t4_stream", 32'(OUT_VALID), 1);
    end
    IN_VALID = 0;
    step();
    step();
    // duplicate destinations
    pkt(18'h3, 0, 1, 18'h3, 0, 16'h0003); IN_VALID = 1;
    step();
    IN_VALID = 0;
    chk("t5_token", 32'(OUT_TOKEN), 32'h6);
    chk("t5_dup", 32'(DUP_ERR), 1);
    step();
    chk("t5_single", 32'(OUT_VALID), 0);
    chk("t5_dup_off", 32'(DUP_ERR), 0);
    step();
    // reset in SEND_A of a dual packet
    pkt(18'h111, 0, 1, 18'h222, 1, 16'h5A5A); IN_VALID = 1; OUT_READY = 0;
    step();
    IN_VALID = 0; MR = 0;
    step();
    chk("t6_valid", 32'(OUT_VALID), 0);
    chk("t6_cnt", 32'(TOK_CNT), 0);
    MR = 1; OUT_READY = 1;
    repeat (3) step();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      pkt(18'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 18'($urandom_range(0, 7)),
          1'($urandom), 16'($urandom));
      IN_VALID  = 1'($urandom);
      OUT_READY = $urandom_range(0, 9) < 7;
      MR        = $urandom_range(0, 59) != 0;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
